decode: RTL
===========

Name: decode

Overview:
- RV32I decode stage. Sits between fetch and execute.
- Consumes fetched {pc, raw instruction} beats over a decoupled input. Produces registered decoded_instr beats over a decoupled output into the execute stage.
- Owns field extraction, immediate generation, opcode classification and illegal-encoding detection.
- Buffers at most two beats so that back-pressure from execute never drops or reorders instructions.

Parameters:
- BUFFERED, 1: 1 = two-entry skid buffer, fetched.ready is a pure register output; 0 = single output register, fetched.ready = !out_valid || decoded.ready.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- fetched  decoupled.in  iface  data = {pc[31:0], instr[31:0]}; valid/ready handshake
- decoded  decoupled.out  iface  data = decoded_instr {op, pc[31:0], rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0], funct7[6:0], imm[31:0]}
- flush  input  1  discard all buffered and incoming beats

Behaviour:
- Handshake: a beat transfers on a cycle with valid && ready. Data must stay stable while valid && !ready.
- Decode latency: 1 cycle. A beat accepted in cycle N is presented on decoded in cycle N+1 at the earliest.
- Reset (rst=1 at posedge):
  - main_valid=0, skid_valid=0.
  - decoded.valid=0.
  - fetched.ready=1 in the cycle after reset.
  - decoded.data is don't-care.
- Buffer state machine, BUFFERED=1. States EMPTY, ONE (main only), TWO (main+skid).
  - EMPTY: accept -> ONE.
  - ONE: accept && decoded.ready -> ONE; accept && !ready -> TWO; !accept && ready -> EMPTY; otherwise hold.
  - TWO: fetched.ready=0. decoded.ready -> ONE, with skid moving into main.
  - fetched.ready = !skid_valid (registered).
  - decoded.valid = main_valid.
- Ordering: strict FIFO. Beats are never duplicated or dropped, except on flush.
- Flush:
  - flush=1 at a posedge -> next state EMPTY.
  - Any beat handshaken in that same cycle is discarded.
  - A decoded beat handshaken in the flush cycle counts as delivered.
  - decoded.valid=0 in the following cycle.
  - flush and rst together: reset wins; the result is identical.
- Decoding is combinational on the incoming beat and registered into the buffer.
- Fixed-position fields, always populated from the raw word even when the instruction is invalid:
  - rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20]
  - funct3=instr[14:12], funct7=instr[31:25]
  - pc is passed through unchanged.
- op classification by instr[6:0]. instr[1:0] != 2'b11 forces INSTR_INVAL.
  - 0110111 INSTR_LUI
  - 0010111 INSTR_AUIPC
  - 1101111 INSTR_JAL
  - 1100111 INSTR_JALR, only if funct3=000, else INVAL
  - 1100011 INSTR_BRANCH, funct3 010/011 -> INVAL
  - 0000011 INSTR_LOAD, funct3 011/110/111 -> INVAL
  - 0100011 INSTR_STORE, funct3 >= 011 -> INVAL
  - 0010011 INSTR_OP_IMM
    - funct3=001 requires funct7=0000000
    - funct3=101 requires funct7 in {0000000, 0100000}
    - otherwise -> INVAL
  - 0110011 INSTR_OP
    - funct7=0000000 is legal for all funct3
    - funct7=0100000 is legal only for funct3 000/101
    - otherwise -> INVAL
  - all other opcodes -> INSTR_INVAL
- Immediates, 32-bit, sign-extended from instr[31]:
  - I-type (JALR, LOAD, OP_IMM): {20{i31}, instr[31:20]}
  - S-type: {20{i31}, instr[31:25], instr[11:7]}
  - B-type: {19{i31}, i31, i7, instr[30:25], instr[11:8], 0}
  - U-type: {instr[31:12], 12'b0}
  - J-type: {11{i31}, i31, instr[19:12], i20, instr[30:21], 0}
  - OP and INVAL: imm=0

Test Plan:
- Single beat: pc=0x80000000, instr=0x00500093 -> next cycle decoded.valid=1, op=INSTR_OP_IMM, rd=1, rs1=0, funct3=0, imm=0x00000005, pc=0x80000000.
- Back-pressure: decoded.ready=0 for 4 cycles while 3 consecutive valid beats are offered -> exactly 2 accepted; fetched.ready=0 from the 3rd cycle; after ready=1, beats emerge in order 1, 2, 3 with no gap and no duplicate.
- Immediate extraction:
  - 0xFE208EE3 (beq x1,x2,-4) -> BRANCH, imm=0xFFFFFFFC, rs1=1, rs2=2.
  - 0x123450B7 -> LUI, rd=1, imm=0x12345000.
- Illegal encodings:
  - 0x00000000 -> INSTR_INVAL.
  - 0x02208033 (funct7=0000001) -> INSTR_INVAL.
  - 0x40208033 -> INSTR_OP with funct7=0x20.
  - 0x00001067 (JALR, funct3=1) -> INSTR_INVAL.
- Flush in state TWO while a new beat is handshaken -> decoded.valid=0 next cycle, fetched.ready=1, and the next accepted beat is the first one to appear.
- rst asserted mid-stream with both entries full -> decoded.valid=0 next cycle, fetched.ready=1, no stale beat ever emitted.
- Repeat the back-pressure test with BUFFERED=0 -> fetched.ready follows decoded.ready combinationally when full.

Source files
------------

// File: rtl/decode_if.sv
// RV32I decode-stage types plus the decoupled valid/ready channel used
// on both sides of the decode stage.
`timescale 1ns/1ps
package decode_pkg;
  typedef enum logic [3:0] {
    INSTR_INVAL  = 4'd0,
    INSTR_LUI    = 4'd1,
    INSTR_AUIPC  = 4'd2,
    INSTR_JAL    = 4'd3,
    INSTR_JALR   = 4'd4,
    INSTR_BRANCH = 4'd5,
    INSTR_LOAD   = 4'd6,
    INSTR_STORE  = 4'd7,
    INSTR_OP_IMM = 4'd8,
    INSTR_OP     = 4'd9
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } decoded_instr_t;
endpackage

interface decode_if #(parameter int W = 64);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/decode.sv
// RV32I decode stage: combinational field/immediate/legality decode of the
// fetched beat, registered into a one- or two-entry FIFO toward execute.
`timescale 1ns/1ps
module decode
  import decode_pkg::*;
#(
  parameter bit BUFFERED = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  decode_if.slave  fetched,
  decode_if.master decoded
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t         state;
  decoded_instr_t main_q, skid_q, dec;
  op_t            op;
  logic [31:0]    ins;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic           acc, deq;

  assign ins = fetched.data[31:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    op = INSTR_INVAL;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'b0110111: op = INSTR_LUI;
        7'b0010111: op = INSTR_AUIPC;
        7'b1101111: op = INSTR_JAL;
        7'b1100111: if (f3 == 3'b000) op = INSTR_JALR;
        7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) op = INSTR_BRANCH;
        7'b0000011: if (f3 != 3'b011 && f3 < 3'b110) op = INSTR_LOAD;
        7'b0100011: if (f3 < 3'b011) op = INSTR_STORE;
        7'b0010011: begin
          // only the shift encodings constrain funct7
          if (f3 == 3'b001) begin
            if (f7 == 7'b0000000) op = INSTR_OP_IMM;
          end else if (f3 == 3'b101) begin
            if (f7 == 7'b0000000 || f7 == 7'b0100000) op = INSTR_OP_IMM;
          end else begin
            op = INSTR_OP_IMM;
          end
        end
        7'b0110011: begin
          if (f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
            op = INSTR_OP;
        end
        default: op = INSTR_INVAL;
      endcase
    end
  end

  always_comb begin
    dec        = '0;
    dec.op     = op;
    dec.pc     = fetched.data[63:32];
    dec.rd     = ins[11:7];
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.funct3 = f3;
    dec.funct7 = f7;
    case (op)
      INSTR_JALR, INSTR_LOAD, INSTR_OP_IMM:
        dec.imm = {{20{ins[31]}}, ins[31:20]};
      INSTR_STORE:
        dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      INSTR_BRANCH:
        dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      INSTR_LUI, INSTR_AUIPC:
        dec.imm = {ins[31:12], 12'b0};
      INSTR_JAL:
        dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        dec.imm = 32'h0;
    endcase
  end

  // Unbuffered mode lets execute's ready ripple straight through to fetch.
  assign fetched.ready = BUFFERED ? (state != TWO)
                                  : (state == EMPTY || decoded.ready);
  assign decoded.valid = (state != EMPTY);
  assign decoded.data  = main_q;

  assign acc = fetched.valid && fetched.ready;
  assign deq = decoded.valid && decoded.ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q <= dec;
          state  <= ONE;
        end
        ONE: begin
          if (acc && deq) begin
            main_q <= dec;
          end else if (acc) begin
            // unreachable unbuffered: there acc in ONE implies deq
            skid_q <= dec;
            state  <= TWO;
          end else if (deq) begin
            state <= EMPTY;
          end
        end
        TWO: if (deq) begin
          main_q <= skid_q;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
